// File: rtl/im2col_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : im2col_pkg
// Brief   : Shared types and helpers for the im2col read sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package im2col_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } im2col_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             colLast;
    logic             frameLast;
  } im2col_elem_t;

  function automatic int out_w(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic int out_h(input int img_h, input int k, input int stride);
    return (img_h - k) / stride + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/im2col_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : im2col_seq_ctrl_if
// Brief     : Start/base, feature-map read port and output stream of the sequencer.
// Rev       : 1.0  initial release
// ============================================================================
interface im2col_seq_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = im2col_pkg::PIX_W
);
  logic              iStart;
  logic [ADDR_W-1:0] iBaseAddr;
  logic              oRdEn;
  logic [ADDR_W-1:0] oRdAddr;
  logic [DATA_W-1:0] iRdData;
  logic [DATA_W-1:0] oData;
  logic              oValid;
  logic              iReady;
  logic              oColLast;
  logic              oFrameLast;
  logic              oBusy;
  logic              oDone;

  modport master (
    input  iStart, iBaseAddr, iRdData, iReady,
    output oRdEn, oRdAddr, oData, oValid, oColLast, oFrameLast, oBusy, oDone
  );

  modport slave (
    output iStart, iBaseAddr, iRdData, iReady,
    input  oRdEn, oRdAddr, oData, oValid, oColLast, oFrameLast, oBusy, oDone
  );
endinterface
`default_nettype wire

// File: rtl/im2col_seq_ctrl_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module : im2col_skid_fifo
// Brief  : Two-entry FIFO of stream elements; simultaneous push/pop allowed.
// Rev    : 1.0  initial release
// ============================================================================
module im2col_skid_fifo
  import im2col_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_push,
  input  wire im2col_elem_t i_elem,
  input  wire logic         i_pop,
  output im2col_elem_t      o_head,
  output logic [1:0]        o_count
);

  im2col_elem_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_elem;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/im2col_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : im2col_seq_ctrl
// Brief  : Walks every KxK window of the feature map, reads each pixel and
//          streams it with column/frame markers through a 2-entry buffer.
// Rev    : 1.0  initial release
// ============================================================================
module im2col_seq_ctrl
  import im2col_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 16,
  parameter int DATA_W = PIX_W
) (
  input wire logic          iClk,
  input wire logic          iRst,
  im2col_seq_ctrl_if.master bus
);

  localparam int c_OUT_W = out_w(IMG_W, K, STRIDE);
  localparam int c_OUT_H = out_h(IMG_H, K, STRIDE);
  localparam int c_CW    = 16;

  typedef logic [c_CW-1:0] cnt_t;

  localparam cnt_t c_K_MAX  = cnt_t'(K - 1);
  localparam cnt_t c_OX_MAX = cnt_t'(c_OUT_W - 1);
  localparam cnt_t c_OY_MAX = cnt_t'(c_OUT_H - 1);

  im2col_state_t     r_state, w_state_nxt;
  cnt_t              r_kx, r_ky, r_ox, r_oy;
  cnt_t              w_kx_nxt, w_ky_nxt, w_ox_nxt, w_oy_nxt;
  logic [ADDR_W-1:0] r_base, r_addr, w_addr_nxt;
  logic              r_inflight, r_tag_col, r_tag_frame;
  logic              w_col, w_frame, w_pop, w_issue, w_valid;
  logic [2:0]        w_pending;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_rd_data;
  im2col_elem_t      w_head, w_push_elem;

  assign w_col   = (r_kx == c_K_MAX) && (r_ky == c_K_MAX);
  assign w_frame = w_col && (r_ox == c_OX_MAX) && (r_oy == c_OY_MAX);
  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid && bus.iReady;

  // Buffered plus in-flight elements once this cycle's pop has left.
  assign w_pending = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == RUN) && (w_pending < 3'd2);

  always_comb begin
    w_kx_nxt = r_kx;
    w_ky_nxt = r_ky;
    w_ox_nxt = r_ox;
    w_oy_nxt = r_oy;
    if (w_issue) begin
      if (r_kx != c_K_MAX) begin
        w_kx_nxt = r_kx + cnt_t'(1);
      end else begin
        w_kx_nxt = '0;
        if (r_ky != c_K_MAX) begin
          w_ky_nxt = r_ky + cnt_t'(1);
        end else begin
          w_ky_nxt = '0;
          if (r_ox != c_OX_MAX) begin
            w_ox_nxt = r_ox + cnt_t'(1);
          end else begin
            w_ox_nxt = '0;
            w_oy_nxt = (r_oy == c_OY_MAX) ? '0 : r_oy + cnt_t'(1);
          end
        end
      end
    end
    w_addr_nxt = r_base
               + (ADDR_W'(w_oy_nxt) * ADDR_W'(STRIDE) + ADDR_W'(w_ky_nxt)) * ADDR_W'(IMG_W)
               + ADDR_W'(w_ox_nxt) * ADDR_W'(STRIDE) + ADDR_W'(w_kx_nxt);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.iStart) w_state_nxt = RUN;
      RUN:     if (w_issue && w_frame) w_state_nxt = DRAIN;
      // Leave on the accept of the last element so oDone lands the next cycle.
      DRAIN:   if (w_pending == 3'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= IDLE;
      r_kx        <= '0;
      r_ky        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_inflight  <= 1'b0;
      r_tag_col   <= 1'b0;
      r_tag_frame <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_col   <= w_col;
        r_tag_frame <= w_frame;
      end
      if ((r_state == IDLE) && bus.iStart) begin
        r_base <= bus.iBaseAddr;
        r_addr <= bus.iBaseAddr;
        r_kx   <= '0;
        r_ky   <= '0;
        r_ox   <= '0;
        r_oy   <= '0;
      end else begin
        r_addr <= w_addr_nxt;
        r_kx   <= w_kx_nxt;
        r_ky   <= w_ky_nxt;
        r_ox   <= w_ox_nxt;
        r_oy   <= w_oy_nxt;
      end
    end
  end

  assign w_rd_data   = bus.iRdData;
  assign w_push_elem = '{data: w_rd_data, colLast: r_tag_col, frameLast: r_tag_frame};

  im2col_skid_fifo u_fifo (
    .clk     (iClk),
    .rst     (iRst),
    .i_push  (r_inflight),
    .i_elem  (w_push_elem),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.oRdEn      = w_issue;
  assign bus.oRdAddr    = r_addr;
  assign bus.oValid     = w_valid;
  assign bus.oData      = w_valid ? w_head.data : '0;
  assign bus.oColLast   = w_valid && w_head.colLast;
  assign bus.oFrameLast = w_valid && w_head.frameLast;
  assign bus.oBusy      = (r_state == RUN) || (r_state == DRAIN);
  assign bus.oDone      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_im2col_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_im2col_seq_ctrl
// Brief  : Directed and randomized checks of im2col_seq_ctrl against a window-walk model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_im2col_seq_ctrl;
  import im2col_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] base = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  int          ncyc = 0;

  always #5 clk = ~clk;

  im2col_seq_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();
  im2col_seq_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus2 ();

  assign bus1.iStart    = start & ~sel;
  assign bus2.iStart    = start & sel;
  assign bus1.iBaseAddr = base;
  assign bus2.iBaseAddr = base;
  assign bus1.iReady    = ready;
  assign bus2.iReady    = ready;

  // Feature-map RAM: each pixel holds the low byte of its own address.
  always @(posedge clk) begin
    if (bus1.oRdEn) bus1.iRdData <= bus1.oRdAddr[7:0];
    if (bus2.oRdEn) bus2.iRdData <= bus2.oRdAddr[7:0];
  end

  im2col_seq_ctrl dut1 (.iClk(clk), .iRst(rst), .bus(bus1.master));
  im2col_seq_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) dut2 (.iClk(clk), .iRst(rst), .bus(bus2.master));

  logic        m_rden, m_valid, m_col, m_frame, m_busy, m_done;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  assign m_rden  = sel ? bus2.oRdEn      : bus1.oRdEn;
  assign m_addr  = sel ? bus2.oRdAddr    : bus1.oRdAddr;
  assign m_valid = sel ? bus2.oValid     : bus1.oValid;
  assign m_data  = sel ? bus2.oData      : bus1.oData;
  assign m_col   = sel ? bus2.oColLast   : bus1.oColLast;
  assign m_frame = sel ? bus2.oFrameLast : bus1.oFrameLast;
  assign m_busy  = sel ? bus2.oBusy      : bus1.oBusy;
  assign m_done  = sel ? bus2.oDone      : bus1.oDone;

  logic [15:0] q_addr[$];
  logic [7:0]  q_data[$];
  logic        q_col[$];
  logic        q_frame[$];
  int          first_rd, first_v, last_acc, done_cnt, done_cyc, issued, accepted;
  bit          hold_pend = 1'b0;
  bit          mon_on = 1'b0;
  logic [9:0]  hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (mon_on) chk("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
    if (hold_pend && !rst) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_elem", 32'({m_data, m_col, m_frame}), 32'(hold_val));
    end
    hold_pend = m_valid && !ready && !rst;
    hold_val  = {m_data, m_col, m_frame};
    if (m_rden) begin
      q_addr.push_back(m_addr);
      issued++;
      if (first_rd < 0) first_rd = ncyc;
    end
    if (m_valid && first_v < 0) first_v = ncyc;
    if (m_valid && ready) begin
      q_data.push_back(m_data);
      q_col.push_back(m_col);
      q_frame.push_back(m_frame);
      accepted++;
      chk("frame_implies_col", 32'(!m_frame || m_col), 32'd1);
      if (m_frame) last_acc = ncyc;
    end
    if (m_done) begin
      done_cnt++;
      done_cyc = ncyc;
      chk("busy_low_in_done", 32'(m_busy), 32'd0);
    end
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic clear_mon();
    q_addr.delete(); q_data.delete(); q_col.delete(); q_frame.delete();
    first_rd = -1; first_v = -1; last_acc = -1; done_cnt = 0; done_cyc = -1;
    issued = 0; accepted = 0; hold_pend = 1'b0; mon_on = 1'b1;
  endtask

  function automatic bit ready_pat(input int mode, input int k);
    if (mode == 1) return (k >= 12 && k < 32) ? 1'b0 : (k % 2 == 0);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_rden"},  32'(m_rden),  32'd0);
    chk({tag, "_addr"},  32'(m_addr),  32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_data"},  32'(m_data),  32'd0);
    chk({tag, "_marks"}, 32'({m_col, m_frame}), 32'd0);
    chk({tag, "_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_done"},  32'(m_done),  32'd0);
  endtask

  task automatic run_frame(input bit s2, input logic [15:0] b, input int mode,
                           input bit repulse, output int t0);
    clear_mon();
    sel = s2; base = b; start = 1'b1; t0 = ncyc;
    for (int k = 0; k < 600; k++) begin
      if (k == 1) start = 1'b0;
      if (repulse && k == 4) begin start = 1'b1; base = 16'h0000; end
      if (repulse && k == 5) start = 1'b0;
      ready = ready_pat(mode, k);
      if (mode == 1 && k == 31) chk("stall_outstanding", 32'(issued - accepted), 32'd2);
      step();
      if (done_cnt > 0) break;
    end
    if (done_cnt == 0) chk("timeout_no_done", 32'd0, 32'd1);
    ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic check_frame(input bit s2, input logic [15:0] b, input int t0, input bit lat);
    int w, s, ow, oh;
    logic [15:0] e_addr[$];
    logic        e_col[$], e_frame[$];
    w = s2 ? 5 : 4; s = s2 ? 2 : 1;
    ow = (w - 3) / s + 1; oh = ow;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            e_addr.push_back(16'(int'(b) + (oy * s + ky) * w + ox * s + kx));
            e_col.push_back(ky == 2 && kx == 2);
            e_frame.push_back(ky == 2 && kx == 2 && ox == ow - 1 && oy == oh - 1);
          end
    chk("n_reads", 32'(q_addr.size()), 32'(e_addr.size()));
    chk("n_elems", 32'(q_data.size()), 32'(e_addr.size()));
    for (int i = 0; i < e_addr.size(); i++) begin
      if (i < q_addr.size()) chk($sformatf("rd_addr[%0d]", i), 32'(q_addr[i]), 32'(e_addr[i]));
      if (i < q_data.size()) begin
        chk($sformatf("data[%0d]", i), 32'(q_data[i]), 32'(e_addr[i][7:0]));
        chk($sformatf("col_last[%0d]", i), 32'(q_col[i]), 32'(e_col[i]));
        chk($sformatf("frame_last[%0d]", i), 32'(q_frame[i]), 32'(e_frame[i]));
      end
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_after_last", 32'(done_cyc), 32'(last_acc + 1));
    if (lat) begin
      chk("lat_first_rden", 32'(first_rd - t0), 32'd1);
      chk("lat_first_valid", 32'(first_v - t0), 32'd3);
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    run_frame(1'b0, 16'h0100, 0, 1'b0, t0);
    check_frame(1'b0, 16'h0100, t0, 1'b1);
    if (q_addr.size() >= 36) begin
      chk("t1_col0_end", 32'(q_addr[8]), 32'h010A);
      chk("t1_last_addr", 32'(q_addr[35]), 32'h010F);
    end else chk("t1_addr_count", 32'(q_addr.size()), 32'd36);

    run_frame(1'b0, 16'h0100, 1, 1'b0, t0);
    check_frame(1'b0, 16'h0100, t0, 1'b0);

    run_frame(1'b1, 16'h0000, 0, 1'b0, t0);
    check_frame(1'b1, 16'h0000, t0, 1'b1);
    if (q_addr.size() >= 36) begin
      chk("s2_col1_start", 32'(q_addr[9]),  32'h0002);
      chk("s2_col2_start", 32'(q_addr[18]), 32'h000A);
      chk("s2_col3_start", 32'(q_addr[27]), 32'h000C);
    end else chk("s2_addr_count", 32'(q_addr.size()), 32'd36);

    run_frame(1'b0, 16'hFFFC, 0, 1'b1, t0);
    check_frame(1'b0, 16'hFFFC, t0, 1'b1);
    if (q_addr.size() >= 4) chk("wrap_addr3", 32'(q_addr[3]), 32'h0000);

    for (int r = 0; r < 3; r++) begin
      logic [15:0] rb;
      bit          rs;
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_frame(rs, rb, 2, 1'b0, t0);
      check_frame(rs, rb, t0, 1'b0);
    end

    clear_mon();
    mon_on = 1'b0;
    sel = 1'b0; base = 16'h0100; start = 1'b1; ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) start = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    check_zero("mid_reset");
    repeat (18) step();
    rst = 1'b0;
    repeat (3) step();
    chk("no_done_on_abort", 32'(done_cnt), 32'd0);

    run_frame(1'b0, 16'h0100, 0, 1'b0, t0);
    check_frame(1'b0, 16'h0100, t0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
